// File: rtl/sync_ff_pkg.sv
// Shared definitions for the sync_ff arbiter slice.
//   MAX_REQ      - largest supported requester count
//   arb_state_e  - EMPTY/FULL view of the output register (assertions/debug only)
//   rr_pick()    - round-robin winner search over a request vector from a start pointer
package sync_ff_pkg;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_SRC_W = 4;
  localparam int unsigned IDX_W     = MAX_SRC_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_SRC_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ..., n_req-1, 0, ..., ptr-1 and return the first asserted request.
  // ptr < n_req and i < n_req, so a single conditional subtract implements the wrap
  // without a modulo, which also keeps non-power-of-two counts correct.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_SRC_W-1:0] ptr,
                                       input int unsigned          n_req);
    rr_pick_t         res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + IDX_W'(i);
      if (idx >= IDX_W'(n_req)) begin
        idx = idx - IDX_W'(n_req);
      end
      if (i < n_req && !res.found && req[idx[MAX_SRC_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MAX_SRC_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_rr_arbiter.sv
// Round-robin winner selection plus the rotating priority pointer.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (pointer returns to 0)
//   req_i   - request vector, already masked by the caller during reset
//   load_i  - output register can accept a word this cycle
//   gnt_o   - one-hot grant, zero when nothing is accepted
//   win_o   - index of the winning requester (valid when xfer_o)
//   xfer_o  - a transfer happens on the coming edge
module sync_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SRC_W = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             load_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0] win_o,
  output logic             xfer_o
);
  import sync_ff_pkg::*;

  rr_pick_t         pick;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             unused_pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req_i), MAX_SRC_W'(ptr_q), N_REQ);
  end

  assign win_o  = pick.idx[SRC_W-1:0];
  assign xfer_o = pick.found & load_i;
  assign gnt_o  = xfer_o ? (N_REQ'(1) << win_o) : '0;

  // Upper index bits are always zero for this N_REQ.
  assign unused_pick = ^pick.idx;

  // Priority moves to the requester after the winner; explicit wrap for non-pow2 counts.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_o) begin
      ptr_d = (win_o == SRC_W'(N_REQ - 1)) ? '0 : win_o + SRC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sync_ff_arbiter.sv
// Round-robin arbiter feeding one shared DATA_W output holding register.
//   CLK       - clock, all logic on posedge
//   RESET     - synchronous active-high reset
//   REQ       - per-requester valid, held with its data until granted
//   REQ_DATA  - packed words, requester i at [i*DATA_W +: DATA_W]
//   GNT       - combinational one-hot accept strobe (zero when none)
//   DOUT      - held word
//   DOUT_VLD  - DOUT holds an unconsumed word
//   DOUT_SRC  - requester index that supplied DOUT
//   DOUT_ACK  - consumer takes DOUT (ignored while DOUT_VLD=0)
module sync_ff_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned SRC_W  = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  output logic [N_REQ-1:0]        GNT,
  output logic [DATA_W-1:0]       DOUT,
  output logic                    DOUT_VLD,
  output logic [SRC_W-1:0]        DOUT_SRC,
  input  logic                    DOUT_ACK
);
  import sync_ff_pkg::*;

  logic [N_REQ-1:0]  req_live;
  logic              load;
  logic              xfer;
  logic [SRC_W-1:0]  win;
  logic [DATA_W-1:0] win_word;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              vld_q, vld_d;

  // Requests are ignored in the reset cycle so no grant can escape it.
  assign req_live = RESET ? '0 : REQ;

  // Register is free now, or is being emptied this same cycle (no bubble on ack).
  assign load = !vld_q || DOUT_ACK;

  sync_rr_arbiter #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_arb (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .req_i  (req_live),
    .load_i (load),
    .gnt_o  (GNT),
    .win_o  (win),
    .xfer_o (xfer)
  );

  assign win_word = REQ_DATA[win*DATA_W +: DATA_W];

  always_comb begin
    dout_d = dout_q;
    src_d  = src_q;
    vld_d  = vld_q;
    if (xfer) begin
      dout_d = win_word;
      src_d  = win;
      vld_d  = 1'b1;
    end else if (DOUT_ACK) begin
      // Word and source stay visible after the consumer drains the register.
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dout_q <= '0;
      src_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      src_q  <= src_d;
      vld_q  <= vld_d;
    end
  end

  assign DOUT     = dout_q;
  assign DOUT_SRC = src_q;
  assign DOUT_VLD = vld_q;

  arb_state_e state;
  assign state = arb_state_e'(vld_q);

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(GNT));
  a_gnt_in_req: assert property (@(posedge CLK) disable iff (RESET) (GNT & ~REQ) == '0);
  a_full_hold:  assert property (@(posedge CLK) disable iff (RESET)
                                 (state == FULL && !DOUT_ACK) |-> (GNT == '0));

endmodule

// File: tb/tb_sync_ff_arbiter.sv
// Bench for sync_ff_arbiter: a 4-requester and a 3-requester instance driven in lockstep,
// each checked every cycle against a transaction-level model of the arbiter.
module tb_sync_ff_arbiter;

  localparam int unsigned DW = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          rst4, ack4, vld4;
  logic [3:0]    req4, gnt4;
  logic [4*DW-1:0] data4;
  logic [DW-1:0] dout4;
  logic [1:0]    src4;

  logic          rst3, ack3, vld3;
  logic [2:0]    req3, gnt3;
  logic [3*DW-1:0] data3;
  logic [DW-1:0] dout3;
  logic [1:0]    src3;

  sync_ff_arbiter #(.DATA_W(DW), .N_REQ(4)) u_dut4 (
    .CLK      (CLK),
    .RESET    (rst4),
    .REQ      (req4),
    .REQ_DATA (data4),
    .GNT      (gnt4),
    .DOUT     (dout4),
    .DOUT_VLD (vld4),
    .DOUT_SRC (src4),
    .DOUT_ACK (ack4)
  );

  sync_ff_arbiter #(.DATA_W(DW), .N_REQ(3)) u_dut3 (
    .CLK      (CLK),
    .RESET    (rst3),
    .REQ      (req3),
    .REQ_DATA (data3),
    .GNT      (gnt3),
    .DOUT     (dout3),
    .DOUT_VLD (vld3),
    .DOUT_SRC (src3),
    .DOUT_ACK (ack3)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state, index 0 = 4-requester instance, index 1 = 3-requester instance.
  int          m_n [2] = '{4, 3};
  logic        m_pend [2][4];
  logic [31:0] m_wd [2][4];
  logic        m_ack [2];
  logic        m_rst [2];
  logic        m_vld [2];
  logic [31:0] m_dout [2];
  int          m_src [2];
  int          m_ptr [2];
  logic        e_x [2];
  int          e_w [2];

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req4[i]            = m_pend[0][i];
      data4[i*DW +: DW]  = m_wd[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      req3[i]            = m_pend[1][i];
      data3[i*DW +: DW]  = m_wd[1][i];
    end
    ack4 = m_ack[0];
    rst4 = m_rst[0];
    ack3 = m_ack[1];
    rst3 = m_rst[1];
  endtask

  task automatic eval();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [31:0] exp_g, got_g, got_d, got_v, got_s;
      int          idx;
      e_x[d] = 1'b0;
      e_w[d] = 0;
      if (!m_rst[d] && (!m_vld[d] || m_ack[d])) begin
        for (int k = 0; k < m_n[d]; k++) begin
          idx = (m_ptr[d] + k) % m_n[d];
          if (!e_x[d] && m_pend[d][idx]) begin
            e_x[d] = 1'b1;
            e_w[d] = idx;
          end
        end
      end
      exp_g = e_x[d] ? (32'd1 << e_w[d]) : 32'd0;
      if (d == 0) begin
        got_g = 32'(gnt4); got_d = dout4; got_v = 32'(vld4); got_s = 32'(src4);
      end else begin
        got_g = 32'(gnt3); got_d = dout3; got_v = 32'(vld3); got_s = 32'(src3);
      end
      check($sformatf("n%0d gnt", m_n[d]), got_g, exp_g);
      check($sformatf("n%0d dout", m_n[d]), got_d, m_dout[d]);
      check($sformatf("n%0d vld", m_n[d]), got_v, 32'(m_vld[d]));
      check($sformatf("n%0d src", m_n[d]), got_s, 32'(m_src[d]));
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      if (m_rst[d]) begin
        m_vld[d]  = 1'b0;
        m_dout[d] = '0;
        m_src[d]  = 0;
        m_ptr[d]  = 0;
      end else if (e_x[d]) begin
        m_dout[d]         = m_wd[d][e_w[d]];
        m_src[d]          = e_w[d];
        m_vld[d]          = 1'b1;
        m_ptr[d]          = (e_w[d] + 1) % m_n[d];
        m_pend[d][e_w[d]] = 1'b0;
      end else if (m_vld[d] && m_ack[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic step();
    drive();
    eval();
    advance();
  endtask

  task automatic raise_all(input int d);
    for (int i = 0; i < m_n[d]; i++) begin
      if (!m_pend[d][i]) begin
        m_pend[d][i] = 1'b1;
        m_wd[d][i]   = $urandom;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[d][i] = 1'b0;
        m_wd[d][i]   = '0;
      end
      m_ack[d]  = 1'b0;
      m_rst[d]  = 1'b1;
      m_vld[d]  = 1'b0;
      m_dout[d] = '0;
      m_src[d]  = 0;
      m_ptr[d]  = 0;
      e_x[d]    = 1'b0;
      e_w[d]    = 0;
    end
    drive();
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset held with every requester asserting.
    raise_all(0);
    repeat (3) begin
      drive();
      eval();
      check("rst gnt", 32'(gnt4), 32'd0);
      advance();
      check("rst vld", 32'(vld4), 32'd0);
    end
    m_rst[0] = 1'b0;
    m_rst[1] = 1'b0;

    // Round-robin with all requesters busy and the consumer always ready.
    m_ack[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      raise_all(0);
      drive();
      eval();
      check("rr gnt", 32'(gnt4), 32'd1 << (c % 4));
      advance();
      check("rr vld", 32'(vld4), 32'd1);
    end
    repeat (4) step();
    check("drain vld", 32'(vld4), 32'd0);

    // Single requester, consumer stalled.
    m_ack[0]     = 1'b0;
    m_pend[0][2] = 1'b1;
    m_wd[0][2]   = 32'hDEAD_BEEF;
    drive();
    eval();
    check("single gnt", 32'(gnt4), 32'h4);
    advance();
    check("single dout", dout4, 32'hDEAD_BEEF);
    check("single src", 32'(src4), 32'd2);
    check("single vld", 32'(vld4), 32'd1);
    repeat (2) begin
      drive();
      eval();
      check("hold gnt", 32'(gnt4), 32'd0);
      advance();
      check("hold dout", dout4, 32'hDEAD_BEEF);
    end

    // Ack with no request drains the register but keeps the word.
    m_ack[0] = 1'b1;
    step();
    check("ackonly vld", 32'(vld4), 32'd0);
    check("ackonly dout", dout4, 32'hDEAD_BEEF);

    // Pointer sits at 3; requesters 0 and 1 must win in that order.
    m_pend[0][0] = 1'b1; m_wd[0][0] = $urandom;
    m_pend[0][1] = 1'b1; m_wd[0][1] = $urandom;
    drive();
    eval();
    check("skip gnt0", 32'(gnt4), 32'h1);
    advance();
    drive();
    eval();
    check("skip gnt1", 32'(gnt4), 32'h2);
    advance();

    // Three requesters: wrap 0,1,2,0, then reset while full.
    m_ack[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      raise_all(1);
      drive();
      eval();
      check("wrap gnt", 32'(gnt3), 32'd1 << (c % 3));
      advance();
    end
    raise_all(1);
    m_ack[1] = 1'b0;
    m_rst[1] = 1'b1;
    drive();
    eval();
    check("rst3 gnt", 32'(gnt3), 32'd0);
    advance();
    check("rst3 vld", 32'(vld3), 32'd0);
    check("rst3 dout", dout3, 32'd0);
    m_rst[1] = 1'b0;
    m_ack[1] = 1'b1;
    drive();
    eval();
    check("post rst gnt", 32'(gnt3), 32'h1);
    advance();

    // Random traffic on both instances, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < m_n[d]; i++) begin
          if (!m_pend[d][i] && $urandom_range(1) == 1) begin
            m_pend[d][i] = 1'b1;
            m_wd[d][i]   = $urandom;
          end
        end
        m_ack[d] = ($urandom_range(3) != 0);
        m_rst[d] = ($urandom_range(63) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
